text_renderer: RTL
==================

# text_renderer

Parametrised text-mode pixel renderer for the VGA path. It maps the current scan coordinate to a character cell and fetches the cell's code and colour attributes from the text RAM. It then fetches the glyph row from the glyph ROM and emits one pixel per clock, as a colour-palette index, through a fixed 4-stage pipeline. It adds two things to the painter path: per-cell foreground/background attributes and a blinking underline cursor.

## Interface
Parameters:
- FONT_W, 8: glyph width in pixels (glyph_data bits).
- FONT_H, 16: glyph height in rows.
- COLS, 80: text columns.
- ROWS, 30: text rows.
- CODE_W, 8: character code width.
- BLINK_FRAMES, 30: frames per cursor blink half-period (≥1).

Derived widths:
- TEXT_AW = $clog2(COLS*ROWS).
- GLYPH_AW = CODE_W + $clog2(FONT_H).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hcoord  in  10  horizontal pixel coordinate.
- vcoord  in  10  vertical pixel coordinate.
- active  in  1  visible-area flag from the VGA timing block.
- frame_start  in  1  one-cycle pulse per frame.
- cursor_en  in  1  cursor enable.
- cursor_col  in  $clog2(COLS)  cursor column.
- cursor_row  in  $clog2(ROWS)  cursor row.
- text_addr  out  TEXT_AW  text RAM read address (registered).
- text_data  in  CODE_W+8  text word: [CODE_W-1:0] code, [CODE_W+3:CODE_W] fg index, [CODE_W+7:CODE_W+4] bg index.
- glyph_addr  out  GLYPH_AW  glyph ROM address (registered).
- glyph_data  in  FONT_W  glyph row; MSB is the leftmost pixel.
- pix_on  out  1  foreground pixel flag.
- color_idx  out  4  palette index.
- pix_valid  out  1  pixel is inside the text area and active.

## Operation
- Cell index: col = hcoord/FONT_W, row = vcoord/FONT_H, grow = vcoord%FONT_H, bit = hcoord%FONT_W.
- in_range = active && hcoord < COLS*FONT_W && vcoord < ROWS*FONT_H.
- text_addr = row*COLS + col when in_range, else 0.
- glyph_addr = code*FONT_H + grow. Arithmetic is unsigned and truncated to the port width.
- Pixel bit = glyph_data[FONT_W-1-bit].
- Sideband values (bit, grow, in_range, cursor_hit) travel in pipeline registers alongside the memory accesses.
- Cursor phase logic:
  - blink_cnt counts frame_start pulses 0..BLINK_FRAMES-1.
  - On a pulse when blink_cnt = BLINK_FRAMES-1, blink_cnt wraps to 0 and phase toggles.
  - visible = cursor_en && phase==0.
- cursor_hit = visible && col==cursor_col && row==cursor_row && grow ≥ FONT_H-2 (two-row underline). It is evaluated in stage 0.
- Pixel output:
  - pix_on = bit XOR cursor_hit.
  - color_idx = pix_on ? fg : bg.
- When !in_range: pix_valid=0, pix_on=0, color_idx=0.
- Reset values: all pipeline registers, text_addr, glyph_addr, pix_on, color_idx, pix_valid, blink_cnt and phase are 0. The cursor is therefore visible right after reset.
- Reset mid-operation clears every stage at once. No partial pixel is emitted after release.

## Timing
- The external RAM and ROM each have one-cycle registered read latency.
- Pipeline, for coordinates sampled at edge k:
  - Edge k: text_addr and stage-0 sideband registered.
  - Edge k+1: text RAM returns text_data.
  - Edge k+2: glyph_addr, fg and bg registered.
  - Edge k+3: glyph ROM returns glyph_data.
  - Edge k+4: pix_on, color_idx and pix_valid registered.
- Latency is 4 clocks; throughput is 1 pixel/clk with no stalls.
- frame_start and a pixel in the same cycle: the new phase applies to stage-0 evaluation from the next edge onward.
- After rst deasserts, pix_valid stays 0 until the first in_range coordinate has crossed all 4 stages.

## Test plan
1. Reset: assert rst asynchronously mid-stream -> all outputs go to 0 immediately; blink_cnt and phase are 0.
2. Cell (0,0) word {bg=1, fg=F, code=0x41}, ROM row 0 = 0x18, sweep h=0..7, v=0 -> text_addr=0 and glyph_addr=0x410. Four clocks later, pix_on = 0,0,0,1,1,0,0,0 and color_idx = 1,1,1,F,F,1,1,1.
3. Corner and bounds: h=639, v=479 -> text_addr=2399, glyph row 15, pix_valid=1. h=640 or active=0 -> pix_valid=0, color_idx=0.
4. Cursor blink (BLINK_FRAMES=2, cursor (3,2), blank cell, bg=2, fg=7):
   - Frames 0-1: v=46,47 with h=24..31 -> pix_on=1, color_idx=7. Row v=45 is unaffected.
   - Frames 2-3: the same pixels give pix_on=0, color_idx=2.
5. Streaming: 800 back-to-back coordinates -> exactly one output per clock, each 4 clocks after its input, with no gaps.
6. cursor_en=0 across a blink toggle -> no inversion anywhere; blink_cnt still advances.

Source files
------------

// File: rtl/text_renderer.sv
// Text-mode pixel renderer: scan coordinate -> text cell -> glyph row -> palette index,
// as a fixed 4-stage pipeline with per-cell fg/bg attributes and a blinking underline cursor.
module text_renderer #(
    parameter int unsigned FONT_W       = 8,
    parameter int unsigned FONT_H       = 16,
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned CODE_W       = 8,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned TEXT_AW     = $clog2(COLS * ROWS),
    localparam int unsigned GLYPH_AW    = CODE_W + $clog2(FONT_H),
    localparam int unsigned COL_W       = $clog2(COLS),
    localparam int unsigned ROW_W       = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            hcoord,
    input  logic [9:0]            vcoord,
    input  logic                  active,
    input  logic                  frame_start,
    input  logic                  cursor_en,
    input  logic [COL_W-1:0]      cursor_col,
    input  logic [ROW_W-1:0]      cursor_row,
    output logic [TEXT_AW-1:0]    text_addr,
    input  logic [CODE_W+7:0]     text_data,
    output logic [GLYPH_AW-1:0]   glyph_addr,
    input  logic [FONT_W-1:0]     glyph_data,
    output logic                  pix_on,
    output logic [3:0]            color_idx,
    output logic                  pix_valid
);

    localparam int unsigned BIT_W  = (FONT_W > 1) ? $clog2(FONT_W) : 1;
    localparam int unsigned GROW_W = (FONT_H > 1) ? $clog2(FONT_H) : 1;
    localparam int unsigned BC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [31:0] h_full, v_full, col_full, row_full, grow_full;
    logic        in_range, visible, cursor_hit;

    logic [BC_W-1:0] blink_cnt;
    logic            phase;

    logic [BIT_W-1:0]  bit0, bit1, bit2, bit3;
    logic [GROW_W-1:0] grow0, grow1;
    logic              inr0, inr1, inr2, inr3;
    logic              hit0, hit1, hit2, hit3;
    logic [3:0]        fg2, bg2, fg3, bg3;

    logic [FONT_W-1:0] glyph_rev;
    logic              pix_next;

    always_comb begin
        h_full     = 32'(hcoord);
        v_full     = 32'(vcoord);
        col_full   = h_full / FONT_W;
        row_full   = v_full / FONT_H;
        grow_full  = v_full % FONT_H;
        in_range   = active && (h_full < COLS * FONT_W) && (v_full < ROWS * FONT_H);
        visible    = cursor_en && !phase;
        cursor_hit = visible && (col_full == 32'(cursor_col)) &&
                     (row_full == 32'(cursor_row)) && (grow_full >= FONT_H - 2);
    end

    // Reverse once so the sideband pixel column indexes directly (MSB is leftmost).
    always_comb begin
        glyph_rev = {<<{glyph_data}};
        pix_next  = glyph_rev[bit3] ^ hit3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_start) begin
            if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            text_addr  <= '0;
            bit0       <= '0;
            grow0      <= '0;
            inr0       <= 1'b0;
            hit0       <= 1'b0;
            bit1       <= '0;
            grow1      <= '0;
            inr1       <= 1'b0;
            hit1       <= 1'b0;
            glyph_addr <= '0;
            fg2        <= '0;
            bg2        <= '0;
            bit2       <= '0;
            inr2       <= 1'b0;
            hit2       <= 1'b0;
            fg3        <= '0;
            bg3        <= '0;
            bit3       <= '0;
            inr3       <= 1'b0;
            hit3       <= 1'b0;
            pix_on     <= 1'b0;
            color_idx  <= '0;
            pix_valid  <= 1'b0;
        end else begin
            // Stage 0: cell address and sideband
            text_addr <= in_range ? TEXT_AW'(row_full * COLS + col_full) : '0;
            bit0      <= BIT_W'(h_full % FONT_W);
            grow0     <= GROW_W'(grow_full);
            inr0      <= in_range;
            hit0      <= cursor_hit;
            // Stage 1: aligned with text RAM read
            bit1      <= bit0;
            grow1     <= grow0;
            inr1      <= inr0;
            hit1      <= hit0;
            // Stage 2: glyph address and attributes
            glyph_addr <= GLYPH_AW'(32'(text_data[CODE_W-1:0]) * FONT_H + 32'(grow1));
            fg2        <= text_data[CODE_W+3:CODE_W];
            bg2        <= text_data[CODE_W+7:CODE_W+4];
            bit2       <= bit1;
            inr2       <= inr1;
            hit2       <= hit1;
            // Stage 3: aligned with glyph ROM read
            fg3        <= fg2;
            bg3        <= bg2;
            bit3       <= bit2;
            inr3       <= inr2;
            hit3       <= hit2;
            // Output
            pix_on     <= inr3 & pix_next;
            color_idx  <= !inr3 ? 4'd0 : (pix_next ? fg3 : bg3);
            pix_valid  <= inr3;
        end
    end

endmodule
